lemming_dig_sched: RTL

- Scheduler that shares a limited "dig skill" budget among N_LEM lemming FSMs.
- Each lemming FSM has a one-cycle dig input and reports walking/digging status.
- Collects dig requests, arbitrates round-robin among lemmings currently walking, and issues one dig pulse at a time.
- Charges the budget only when the lemming confirms digging, then holds the grant until digging ends.

---
 rtl/lemming_pkg.sv | 15 +
 rtl/rr_pick.sv | 27 ++
 rtl/lemming_dig_sched.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/lemming_pkg.sv
// rtl/lemming_pkg.sv - shared types and default constants for the dig scheduler
package lemming_pkg;

    localparam int DEF_N_LEM      = 4;
    localparam int DEF_BUDGET_W   = 4;
    localparam int DEF_CONFIRM_TO = 3;
    localparam int DEF_MAX_HOLD   = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        HOLD    = 2'd2
    } sched_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker over an eligibility vector
module rr_pick #(
    parameter  int N_LEM = 4,
    localparam int IDX_W = $clog2(N_LEM)
) (
    input  logic [N_LEM-1:0] eligible_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] winner_o
);

    logic [IDX_W-1:0] idx;

    // Walk downward so the candidate closest to rr_ptr_i is the last one written.
    always_comb begin
        valid_o  = |eligible_i;
        winner_o = '0;
        idx      = '0;
        for (int k = N_LEM - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(rr_ptr_i) + k) % N_LEM);
            if (eligible_i[idx]) begin
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/lemming_dig_sched.sv
// rtl/lemming_dig_sched.sv - round-robin dig-skill scheduler with budget, confirm and hold timeouts
module lemming_dig_sched
    import lemming_pkg::*;
#(
    parameter int N_LEM      = DEF_N_LEM,
    parameter int BUDGET_W   = DEF_BUDGET_W,
    parameter int CONFIRM_TO = DEF_CONFIRM_TO,
    parameter int MAX_HOLD   = DEF_MAX_HOLD
) (
    input  logic                     clk,
    input  logic                     areset_n,
    input  logic [N_LEM-1:0]         req,
    input  logic [N_LEM-1:0]         walking,
    input  logic [N_LEM-1:0]         digging,
    input  logic                     budget_load,
    input  logic [BUDGET_W-1:0]      budget_val,
    output logic [N_LEM-1:0]         dig,
    output logic                     busy,
    output logic [$clog2(N_LEM)-1:0] grant_id,
    output logic [BUDGET_W-1:0]      budget_left,
    output logic                     denied,
    output logic                     fail
);

    localparam int IDX_W = $clog2(N_LEM);
    localparam int TMR_W = $clog2(MAX_HOLD + 1);

    sched_state_e      state_q;
    logic [N_LEM-1:0]  pending_q, pending_d;
    logic [BUDGET_W-1:0] budget_q, budget_d;
    logic [IDX_W-1:0]  rr_ptr_q, grant_q, ptr_after;
    logic [TMR_W-1:0]  timer_q, timer_inc;
    logic [N_LEM-1:0]  dig_q;
    logic              denied_q, fail_q;

    logic [N_LEM-1:0]  eligible;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_winner;
    logic              issue, deny, charge;

    // Non-walking lemmings keep their request pending; they may land later.
    assign eligible = pending_q & walking;

    rr_pick #(.N_LEM(N_LEM)) u_pick (
        .eligible_i (eligible),
        .rr_ptr_i   (rr_ptr_q),
        .valid_o    (pick_valid),
        .winner_o   (pick_winner)
    );

    // Pending-set, budget and timer next-state; new requests always win over clears.
    always_comb begin
        issue     = 1'b0;
        deny      = 1'b0;
        charge    = 1'b0;
        pending_d = pending_q;
        budget_d  = budget_q;
        timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;
        ptr_after = (grant_q == IDX_W'(N_LEM - 1)) ? '0 : grant_q + 1'b1;
        if (state_q == IDLE) begin
            if (budget_q == '0 && pending_q != '0) begin
                deny      = 1'b1;
                pending_d = '0;
            end else if (pick_valid) begin
                issue                  = 1'b1;
                pending_d[pick_winner] = 1'b0;
            end
        end
        if (state_q == CONFIRM && digging[grant_q]) begin
            charge = 1'b1;
        end
        pending_d = pending_d | req;
        if (budget_load) begin
            budget_d = budget_val;
        end else if (charge && budget_q != '0) begin
            budget_d = budget_q - 1'b1;
        end
    end

    // Grant FSM: issue one dig pulse, wait for confirmation, hold until digging ends.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            budget_q  <= '0;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            timer_q   <= '0;
            dig_q     <= '0;
            denied_q  <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            budget_q  <= budget_d;
            dig_q     <= '0;
            denied_q  <= deny;
            fail_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        dig_q   <= N_LEM'(1) << pick_winner;
                        grant_q <= pick_winner;
                        timer_q <= '0;
                        state_q <= CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (charge) begin
                        timer_q <= '0;
                        state_q <= HOLD;
                    end else begin
                        timer_q <= timer_inc;
                        if (timer_inc >= TMR_W'(CONFIRM_TO)) begin
                            fail_q   <= 1'b1;
                            rr_ptr_q <= ptr_after;
                            state_q  <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (!digging[grant_q]) begin
                        rr_ptr_q <= ptr_after;
                        state_q  <= IDLE;
                    end else begin
                        timer_q <= timer_inc;
                        if (timer_inc >= TMR_W'(MAX_HOLD)) begin
                            fail_q   <= 1'b1;
                            rr_ptr_q <= ptr_after;
                            state_q  <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dig         = dig_q;
    assign busy        = (state_q != IDLE);
    assign grant_id    = grant_q;
    assign budget_left = budget_q;
    assign denied      = denied_q;
    assign fail        = fail_q;

endmodule
